// File: rtl/worker_pipe_pkg.sv
// Shared definitions for the pipelined dataflow worker: opcodes, destination
// code, issue states and the result-header builders.
package worker_pipe_pkg;

    localparam logic [9:0] INSN_DISTRIBUTE = 10'h001;
    localparam logic [9:0] INSN_SWITCH     = 10'h002;
    localparam logic [9:0] INSN_SET_COLOR  = 10'h003;
    localparam logic [9:0] INSN_SYNC       = 10'h004;
    localparam logic [9:0] INSN_PLUS       = 10'h005;
    localparam logic [9:0] INSN_MINUS      = 10'h006;
    localparam logic [9:0] INSN_LT         = 10'h007;
    localparam logic [9:0] INSN_EQ         = 10'h008;

    localparam logic [2:0] DEST_DIRECT = 3'b100;
    localparam int         HDR_W       = 35;

    typedef enum logic {
        S_FIRST  = 1'b0,
        S_SECOND = 1'b1
    } issue_state_t;

    function automatic int pkt_w(input int dw);
        return 4 * dw + 47;
    endfunction

    function automatic int res_w(input int dw);
        return dw + HDR_W;
    endfunction

    // Headers are width independent; callers append the DW-wide data word.
    function automatic logic [HDR_W-1:0] make_worker_result(input logic [2:0] dopt,
                                                           input logic [15:0] daddr,
                                                           input logic [15:0] color);
        return {dopt, daddr, color};
    endfunction

    function automatic logic [HDR_W-1:0] make_worker_result_direct(input logic [15:0] addr,
                                                                  input logic [15:0] color);
        return {DEST_DIRECT, addr, color};
    endfunction

    function automatic logic is_legal(input logic [9:0] opc);
        return (opc >= INSN_DISTRIBUTE) && (opc <= INSN_EQ);
    endfunction

    function automatic logic is_pair(input logic [9:0] opc);
        return (opc == INSN_DISTRIBUTE) || (opc == INSN_SYNC);
    endfunction

endpackage

// File: rtl/worker_pipe_if.sv
// Packet-in / result-out handshake bundle; master is the surrounding fabric,
// slave is the worker.
interface worker_pipe_if #(parameter int DW = 32) ();
    import worker_pipe_pkg::*;

    localparam int PKT_W = pkt_w(DW);
    localparam int RES_W = res_w(DW);

    logic             PC_VALID;
    logic [PKT_W-1:0] PC_DATA;
    logic             PC_READY;
    logic             WR_VALID;
    logic [RES_W-1:0] WR_DATA;
    logic             WR_READY;

    modport master (output PC_VALID, PC_DATA, WR_READY,
                    input  PC_READY, WR_VALID, WR_DATA);
    modport slave  (input  PC_VALID, PC_DATA, WR_READY,
                    output PC_READY, WR_VALID, WR_DATA);
endinterface

// File: rtl/worker_fifo.sv
// Synchronous FIFO with a registered array read; an entry becomes visible at
// the head one cycle after it is written.
module worker_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             idle
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_reg;
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg;
    logic             head_valid_reg;
    logic             do_push, do_pop;

    assign do_push     = push && !full;
    assign do_pop      = pop && head_valid_reg;
    assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr_reg] <= din;
        head_reg <= mem[rd_ptr_next];
    end

    // The head is valid only if an entry other than the one being written remains.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            head_valid_reg <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
            head_valid_reg <= (count_reg - (AW+1)'(do_pop)) != '0;
        end
    end

    assign dout  = head_reg;
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = !head_valid_reg;
    assign idle  = (count_reg == '0);
endmodule

// File: rtl/worker_pipe.sv
// Pipelined dataflow worker: buffers packets, issues one result slot per cycle
// (two for pair ops), drops and counts illegal opcodes.
module worker_pipe import worker_pipe_pkg::*; #(
    parameter int DW       = 32,
    parameter int IN_DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    worker_pipe_if.slave bus,
    output logic [15:0]  ILLEGAL_CNT,
    output logic         BUSY
);
    localparam int PKT_W = pkt_w(DW);
    localparam int RES_W = res_w(DW);

    logic [PKT_W-1:0] head;
    logic             fifo_full, fifo_empty, fifo_idle;
    logic             out_free, issue, legal_op, pair_op, load, pop;
    logic [RES_W-1:0] result;
    logic [9:0]       opcode;
    logic [DW-1:0]    d1, d2, d3, d4;
    logic [2:0]       dopt;
    logic [15:0]      daddr, color;
    logic             unused_bits;

    issue_state_t     state_reg;
    logic             wr_valid_reg;
    logic [RES_W-1:0] wr_data_reg;
    logic [15:0]      illegal_cnt_reg;

    worker_fifo #(.WIDTH(PKT_W), .DEPTH(IN_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (bus.PC_VALID),
        .din   (bus.PC_DATA),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .idle  (fifo_idle)
    );

    assign color  = head[15:0];
    assign daddr  = head[31:16];
    assign dopt   = head[34:32];
    assign d4     = head[35 +: DW];
    assign d3     = head[35 + DW +: DW];
    assign d2     = head[35 + 2*DW +: DW];
    assign d1     = head[35 + 3*DW +: DW];
    assign opcode = head[35 + 4*DW +: 10];
    // opmode and the upper bits of the direct addresses play no part here.
    assign unused_bits = ^{head[PKT_W-1 -: 2], d3[DW-1:16], d4[DW-1:16]};

    assign out_free = !wr_valid_reg || bus.WR_READY;
    assign issue    = !fifo_empty && out_free;
    assign legal_op = is_legal(opcode);
    assign pair_op  = is_pair(opcode);
    assign load     = issue && legal_op;
    assign pop      = issue && (!legal_op || !pair_op || state_reg == S_SECOND);

    always_comb begin
        result = '0;
        case (opcode)
            INSN_DISTRIBUTE: result = {make_worker_result_direct(
                                 (state_reg == S_FIRST) ? d2[15:0] : d3[15:0], color), d1};
            INSN_SWITCH:     result = {make_worker_result_direct(
                                 (d2 != '0) ? d3[15:0] : d4[15:0], color), d1};
            INSN_SET_COLOR:  result = {make_worker_result(dopt, daddr, d2[15:0]), d1};
            INSN_SYNC:       result = (state_reg == S_FIRST)
                                 ? {make_worker_result_direct(d3[15:0], color), d1}
                                 : {make_worker_result_direct(d4[15:0], color), d2};
            INSN_PLUS:       result = {make_worker_result(dopt, daddr, color), d1 + d2};
            INSN_MINUS:      result = {make_worker_result(dopt, daddr, color), d1 - d2};
            INSN_LT:         result = {make_worker_result(dopt, daddr, color),
                                       DW'($signed(d1) < $signed(d2))};
            INSN_EQ:         result = {make_worker_result(dopt, daddr, color), DW'(d1 == d2)};
            default:         result = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg       <= S_FIRST;
            wr_valid_reg    <= 1'b0;
            wr_data_reg     <= '0;
            illegal_cnt_reg <= '0;
        end else begin
            if (load) begin
                wr_valid_reg <= 1'b1;
                wr_data_reg  <= result;
            end else if (out_free) begin
                wr_valid_reg <= 1'b0;
            end
            if (load && pair_op)
                state_reg <= (state_reg == S_FIRST) ? S_SECOND : S_FIRST;
            if (issue && !legal_op && illegal_cnt_reg != 16'hFFFF)
                illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
        end
    end

    assign bus.PC_READY = !fifo_full;
    assign bus.WR_VALID = wr_valid_reg;
    assign bus.WR_DATA  = wr_data_reg;
    assign ILLEGAL_CNT  = illegal_cnt_reg;
    assign BUSY         = !fifo_idle || wr_valid_reg;
endmodule

// File: tb/tb_worker_pipe.sv
// Directed bench for worker_pipe: latency, pair ops, backpressure, FIFO fill,
// illegal opcodes, opcode table and async reset mid-pair.
module tb_worker_pipe;
    import worker_pipe_pkg::*;

    localparam int DW    = 32;
    localparam int PKT_W = 4*DW + 47;
    localparam int RES_W = DW + 35;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] illegal_cnt;
    logic        busy;

    worker_pipe_if #(.DW(DW)) bus ();

    worker_pipe #(.DW(DW), .IN_DEPTH(4)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .bus         (bus),
        .ILLEGAL_CNT (illegal_cnt),
        .BUSY        (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [RES_W-1:0] got_q[$];
    int               got_cyc[$];

    // A transfer seen at the falling edge completes on the next rising edge.
    always @(negedge CLK) begin
        if (RST_N && bus.WR_VALID && bus.WR_READY) begin
            got_q.push_back(bus.WR_DATA);
            got_cyc.push_back(cyc);
            $display("result %h at cycle %0d", bus.WR_DATA, cyc);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [PKT_W-1:0] mkpkt(input logic [9:0] opc,
                                               input logic [31:0] d1, input logic [31:0] d2,
                                               input logic [31:0] d3, input logic [31:0] d4,
                                               input logic [2:0] dopt, input logic [15:0] daddr,
                                               input logic [15:0] color);
        return {2'b01, opc, d1, d2, d3, d4, dopt, daddr, color};
    endfunction

    function automatic logic [RES_W-1:0] qget(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_q();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic send(input logic [PKT_W-1:0] p);
        int t = 0;
        bus.PC_DATA  = p;
        bus.PC_VALID = 1'b1;
        while (!bus.PC_READY && t < 50) begin
            tick();
            t++;
        end
        if (!bus.PC_READY) chk("send_timeout", 0, 1);
        tick();
        bus.PC_VALID = 1'b0;
    endtask

    task automatic wait_results(input int n, input string tag);
        int t = 0;
        while (got_q.size() < n && t < 100) begin
            tick();
            t++;
        end
        chk(tag, got_q.size(), n);
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!bus.WR_VALID && t < 50) begin
            tick();
            t++;
        end
        chk(tag, bus.WR_VALID, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (busy && t < 100) begin
            tick();
            t++;
        end
        chk("drain", busy, 0);
        tick();
    endtask

    // Test 1 shape: PLUS 5+7, result two edges after accept.
    task automatic run_plus_latency(input string pfx);
        clear_q();
        send(mkpkt(INSN_PLUS, 32'd5, 32'd7, 32'd0, 32'd0, 3'd1, 16'h0040, 16'd3));
        chk({pfx, "_lat_n0"}, bus.WR_VALID, 0);
        tick();
        chk({pfx, "_lat_n1"}, bus.WR_VALID, 0);
        tick();
        chk({pfx, "_lat_n2"}, bus.WR_VALID, 1);
        chk({pfx, "_data"}, bus.WR_DATA, {3'd1, 16'h0040, 16'd3, 32'd12});
        drain();
        chk({pfx, "_count"}, got_q.size(), 1);
    endtask

    logic [PKT_W-1:0] vec_pkt [7];
    logic [RES_W-1:0] vec_exp [7];

    initial begin
        bus.PC_VALID = 1'b0;
        bus.PC_DATA  = '0;
        bus.WR_READY = 1'b1;
        RST_N        = 1'b0;
        repeat (3) tick();
        chk("rst_wr_valid", bus.WR_VALID, 0);
        chk("rst_wr_data", bus.WR_DATA, 0);
        chk("rst_illegal", illegal_cnt, 0);
        chk("rst_busy", busy, 0);
        RST_N = 1'b1;
        tick();
        chk("rst_pc_ready", bus.PC_READY, 1);

        run_plus_latency("t1");

        // DISTRIBUTE: two direct results on back-to-back cycles.
        clear_q();
        send(mkpkt(INSN_DISTRIBUTE, 32'd9, 32'h10, 32'h20, 32'd0, 3'd0, 16'h0000, 16'd2));
        chk("t2_pc_ready", bus.PC_READY, 1);
        tick();
        tick();
        chk("t2_pc_ready_mid", bus.PC_READY, 1);
        wait_results(2, "t2_n");
        drain();
        chk("t2_r0", qget(0), {3'b100, 16'h0010, 16'h0002, 32'd9});
        chk("t2_r1", qget(1), {3'b100, 16'h0020, 16'h0002, 32'd9});
        chk("t2_back2back", (got_cyc.size() > 1) ? got_cyc[1] - got_cyc[0] : -1, 1);

        // SYNC held under backpressure.
        clear_q();
        bus.WR_READY = 1'b0;
        send(mkpkt(INSN_SYNC, 32'd1, 32'd2, 32'hA, 32'hB, 3'd0, 16'h0000, 16'd7));
        wait_valid("t3_valid");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_hold%0d", i), bus.WR_DATA, {3'b100, 16'h000A, 16'h0007, 32'd1});
            tick();
        end
        bus.WR_READY = 1'b1;
        wait_results(2, "t3_n");
        drain();
        chk("t3_r0", qget(0), {3'b100, 16'h000A, 16'h0007, 32'd1});
        chk("t3_r1", qget(1), {3'b100, 16'h000B, 16'h0007, 32'd2});
        chk("t3_nodup", got_q.size(), 2);

        // Fill: 1 in the output slot + 4 buffered closes PC_READY.
        clear_q();
        bus.WR_READY = 1'b0;
        for (int i = 0; i < 5; i++)
            send(mkpkt(INSN_PLUS, 32'(i + 1), 32'd100, 32'd0, 32'd0, 3'd1, 16'h0040, 16'd3));
        chk("t4_full", bus.PC_READY, 0);
        tick();
        chk("t4_full_hold", bus.PC_READY, 0);
        chk("t4_slot", bus.WR_DATA, {3'd1, 16'h0040, 16'd3, 32'd101});
        bus.WR_READY = 1'b1;
        send(mkpkt(INSN_PLUS, 32'd6, 32'd100, 32'd0, 32'd0, 3'd1, 16'h0040, 16'd3));
        wait_results(6, "t4_n");
        drain();
        for (int i = 0; i < 6; i++)
            chk($sformatf("t4_r%0d", i), qget(i), {3'd1, 16'h0040, 16'd3, 32'(101 + i)});

        // Illegal opcode sandwiched between two PLUS packets.
        clear_q();
        send(mkpkt(INSN_PLUS, 32'd1, 32'd1, 32'd0, 32'd0, 3'd1, 16'h0040, 16'd3));
        send(mkpkt(10'h3FF, 32'd50, 32'd50, 32'd0, 32'd0, 3'd1, 16'h0040, 16'd3));
        send(mkpkt(INSN_PLUS, 32'd2, 32'd2, 32'd0, 32'd0, 3'd1, 16'h0040, 16'd3));
        wait_results(2, "t5_n");
        drain();
        chk("t5_count", got_q.size(), 2);
        chk("t5_r0", qget(0), {3'd1, 16'h0040, 16'd3, 32'd2});
        chk("t5_r1", qget(1), {3'd1, 16'h0040, 16'd3, 32'd4});
        chk("t5_illegal", illegal_cnt, 1);

        // Opcode table, streamed back to back.
        vec_pkt[0] = mkpkt(INSN_MINUS, 32'd5, 32'd7, 32'd0, 32'd0, 3'd2, 16'h1234, 16'h0055);
        vec_exp[0] = {3'd2, 16'h1234, 16'h0055, 32'hFFFF_FFFE};
        vec_pkt[1] = mkpkt(INSN_LT, 32'hFFFF_FFFD, 32'd2, 32'd0, 32'd0, 3'd2, 16'h1234, 16'h0055);
        vec_exp[1] = {3'd2, 16'h1234, 16'h0055, 32'd1};
        vec_pkt[2] = mkpkt(INSN_LT, 32'd2, 32'hFFFF_FFFD, 32'd0, 32'd0, 3'd2, 16'h1234, 16'h0055);
        vec_exp[2] = {3'd2, 16'h1234, 16'h0055, 32'd0};
        vec_pkt[3] = mkpkt(INSN_EQ, 32'd7, 32'd7, 32'd0, 32'd0, 3'd2, 16'h1234, 16'h0055);
        vec_exp[3] = {3'd2, 16'h1234, 16'h0055, 32'd1};
        vec_pkt[4] = mkpkt(INSN_SWITCH, 32'h77, 32'd0, 32'h30, 32'h40, 3'd2, 16'h1234, 16'h0055);
        vec_exp[4] = {3'b100, 16'h0040, 16'h0055, 32'h77};
        vec_pkt[5] = mkpkt(INSN_SWITCH, 32'h77, 32'd1, 32'h30, 32'h40, 3'd2, 16'h1234, 16'h0055);
        vec_exp[5] = {3'b100, 16'h0030, 16'h0055, 32'h77};
        vec_pkt[6] = mkpkt(INSN_SET_COLOR, 32'h99, 32'h0001_BEEF, 32'd0, 32'd0, 3'd2, 16'h1234, 16'h0055);
        vec_exp[6] = {3'd2, 16'h1234, 16'hBEEF, 32'h99};
        clear_q();
        for (int i = 0; i < 7; i++) send(vec_pkt[i]);
        wait_results(7, "vec_n");
        drain();
        for (int i = 0; i < 7; i++)
            chk($sformatf("vec_r%0d", i), qget(i), vec_exp[i]);

        // Async reset while the second half of a pair is pending.
        clear_q();
        bus.WR_READY = 1'b0;
        send(mkpkt(INSN_DISTRIBUTE, 32'd9, 32'h10, 32'h20, 32'd0, 3'd0, 16'h0000, 16'd2));
        send(mkpkt(INSN_PLUS, 32'd3, 32'd3, 32'd0, 32'd0, 3'd1, 16'h0040, 16'd3));
        wait_valid("t6_valid");
        #2 RST_N = 1'b0;
        #1;
        chk("t6_wr_valid", bus.WR_VALID, 0);
        chk("t6_busy", busy, 0);
        chk("t6_illegal", illegal_cnt, 0);
        tick();
        RST_N = 1'b1;
        bus.WR_READY = 1'b1;
        run_plus_latency("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
